// File: rtl/lfsr_galois_checker.sv
// Receive-side PRBS checker: regenerates a Galois-LFSR sequence, tracks HUNT/LOCKED alignment
// and counts bit errors while locked. Define LFSR_CHK_ERRCNT_EN to build the error counter.
module lfsr_galois_checker #(
  parameter int unsigned            POLY_DEGREE  = 7,
  parameter logic [POLY_DEGREE:1]   POLYNOMIAL   = 7'b110_0000,
  parameter logic [POLY_DEGREE:1]   SEED         = '1,
  parameter int unsigned            OUTPUT_WIDTH = 1,
  parameter int unsigned            LOCK_BEATS   = 16,
  parameter int unsigned            LOSS_BEATS   = 4,
  parameter int unsigned            CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic                    clear_count,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [OUTPUT_WIDTH-1:0] s_data,
  output logic                    locked,
  output logic                    err_valid,
  output logic [OUTPUT_WIDTH-1:0] err_bits,
  output logic [CNT_W-1:0]        err_count
);

  localparam int unsigned GW = $clog2(LOCK_BEATS + 1);
  localparam int unsigned BW = $clog2(LOSS_BEATS + 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_BEATS - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_BEATS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                  fsm;
  logic [POLY_DEGREE:1]    lfsr_q;
  logic [POLY_DEGREE:1]    lfsr_nxt;
  logic [OUTPUT_WIDTH-1:0] exp_bits;
  logic [OUTPUT_WIDTH-1:0] err_bits_nxt;
  logic [GW-1:0]           good_run;
  logic [BW-1:0]           bad_run;
  logic                    accept;
  logic                    errored;

  // Unroll OUTPUT_WIDTH bit-serial steps; bit 0 of the beat is the first step's output.
  always_comb begin
    lfsr_nxt = lfsr_q;
    exp_bits = '0;
    for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
      exp_bits[i] = lfsr_nxt[1];
      lfsr_nxt    = (lfsr_nxt >> 1) ^ (lfsr_nxt[1] ? POLYNOMIAL : '0);
    end
  end

  assign err_bits_nxt = s_data ^ exp_bits;
  assign errored      = |err_bits_nxt;
  assign accept       = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      lfsr_q    <= SEED;
      fsm       <= HUNT;
      locked    <= 1'b0;
      err_valid <= 1'b0;
      err_bits  <= '0;
      good_run  <= '0;
      bad_run   <= '0;
    end else begin
      s_ready   <= 1'b1;
      err_valid <= 1'b0;
      if (restart) begin
        // A beat accepted alongside restart is dropped without advancing the LFSR.
        lfsr_q   <= SEED;
        fsm      <= HUNT;
        locked   <= 1'b0;
        good_run <= '0;
        bad_run  <= '0;
      end else if (accept) begin
        lfsr_q    <= lfsr_nxt;
        err_valid <= 1'b1;
        err_bits  <= err_bits_nxt;
        case (fsm)
          HUNT: begin
            if (errored) begin
              good_run <= '0;
            end else if (good_run == LOCK_LAST) begin
              fsm     <= LOCKED;
              locked  <= 1'b1;
              bad_run <= '0;
            end else begin
              good_run <= good_run + 1'b1;
            end
          end
          LOCKED: begin
            if (!errored) begin
              bad_run <= '0;
            end else if (bad_run == LOSS_LAST) begin
              fsm      <= HUNT;
              locked   <= 1'b0;
              good_run <= '0;
            end else begin
              bad_run <= bad_run + 1'b1;
            end
          end
          default: fsm <= HUNT;
        endcase
      end
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  localparam int unsigned PW = $clog2(OUTPUT_WIDTH + 1);

  logic [PW-1:0]  pop;
  logic [CNT_W:0] sum;
  logic           count_en;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
      pop = pop + PW'(err_bits_nxt[i]);
    end
    sum = {1'b0, err_count} + (CNT_W + 1)'(pop);
  end

  assign count_en = accept & ~restart & (fsm == LOCKED) & errored;

  // clear_count takes priority over a coincident errored beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear_count) begin
      err_count <= '0;
    end else if (count_en) begin
      err_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end
`else
  logic unused_clear_count;

  assign unused_clear_count = clear_count;
  assign err_count          = '0;
`endif

endmodule

// File: tb/tb_lfsr_galois_checker.sv
// Self-checking bench for lfsr_galois_checker: a 1-bit default instance and an 8-bit/4-bit-counter
// instance, driven against a bit-serial reference model through an expected-result queue.
module tb_lfsr_galois_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        restart1, clear1, valid1, ready1, locked1, ev1;
  logic [0:0]  data1, eb1;
  logic [31:0] ec1;
  logic        restart8, clear8, valid8, ready8, locked8, ev8;
  logic [7:0]  data8, eb8;
  logic [3:0]  ec8;

  lfsr_galois_checker u_d1 (
    .clk(clk), .rst_n(rst_n), .restart(restart1), .clear_count(clear1),
    .s_valid(valid1), .s_ready(ready1), .s_data(data1), .locked(locked1),
    .err_valid(ev1), .err_bits(eb1), .err_count(ec1)
  );

  lfsr_galois_checker #(.OUTPUT_WIDTH(8), .CNT_W(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .restart(restart8), .clear_count(clear8),
    .s_valid(valid8), .s_ready(ready8), .s_data(data8), .locked(locked8),
    .err_valid(ev8), .err_bits(eb8), .err_count(ec8)
  );

  typedef struct {
    logic [7:0] bits;
    bit         lk;
    longint     cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:1] m_state [2];
  bit         m_lk    [2];
  int         m_good  [2];
  int         m_bad   [2];
  longint     m_cnt   [2];
  longint     saved_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int sel);
    m_state[sel] = 7'h7F;
    m_lk[sel]    = 1'b0;
    m_good[sel]  = 0;
    m_bad[sel]   = 0;
  endtask

  // Drive one beat; val is an error mask over the expected data, or the raw data when raw=1.
  task automatic beat(input int sel, input logic [7:0] val, input bit raw, input bit rst_p,
                      input bit clr);
    logic [7:0] exp_b, data, err, wmask;
    logic [7:1] s;
    longint     cmax;
    exp_t       e;
    int         pc;
    wmask = (sel != 0) ? 8'hFF : 8'h01;
    cmax  = (sel != 0) ? 64'd15 : 64'hFFFF_FFFF;
    s     = m_state[sel];
    exp_b = '0;
    for (int i = 0; i < ((sel != 0) ? 8 : 1); i++) begin
      exp_b[i] = s[1];
      if (s[1]) s = (s >> 1) ^ 7'b110_0000;
      else      s = s >> 1;
    end
    data = (raw ? val : (exp_b ^ val)) & wmask;
    if (sel == 0) begin
      valid1 = 1'b1; data1 = data[0:0]; restart1 = rst_p; clear1 = clr;
    end else begin
      valid8 = 1'b1; data8 = data; restart8 = rst_p; clear8 = clr;
    end
    if (rst_p) begin
      model_reset(sel);
    end else begin
      m_state[sel] = s;
      err = data ^ exp_b;
      pc  = $countones(err);
      if (!m_lk[sel]) begin
        if (err != 0) m_good[sel] = 0;
        else begin
          m_good[sel]++;
          if (m_good[sel] == 16) begin m_lk[sel] = 1'b1; m_bad[sel] = 0; end
        end
      end else begin
        if (err != 0) begin
          m_bad[sel]++;
          if (m_cnt[sel] + pc > cmax) m_cnt[sel] = cmax;
          else                        m_cnt[sel] = m_cnt[sel] + pc;
          if (m_bad[sel] == 4) begin m_lk[sel] = 1'b0; m_good[sel] = 0; end
        end else begin
          m_bad[sel] = 0;
        end
      end
    end
    if (clr) m_cnt[sel] = 0;
    if (!rst_p) begin
      e.bits = err;
      e.lk   = m_lk[sel];
`ifdef LFSR_CHK_ERRCNT_EN
      e.cnt  = m_cnt[sel];
`else
      e.cnt  = 0;
`endif
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    valid1 = 1'b0; restart1 = 1'b0; clear1 = 1'b0;
    valid8 = 1'b0; restart8 = 1'b0; clear8 = 1'b0;
    if (rst_p) begin
      check("restart_drop", (sel != 0) ? ev8 : ev1, 0);
      check("restart_hunt", (sel != 0) ? locked8 : locked1, 0);
    end else begin
      e = sb.pop_front();
      if (sel == 0) begin
        check("d1_valid", ev1, 1);
        check("d1_bits", eb1, e.bits);
        check("d1_locked", locked1, e.lk);
        check("d1_count", ec1, e.cnt);
      end else begin
        check("d8_valid", ev8, 1);
        check("d8_bits", eb8, e.bits);
        check("d8_locked", locked8, e.lk);
        check("d8_count", ec8, e.cnt);
      end
    end
  endtask

  task automatic clean(input int sel, input int n);
    for (int i = 0; i < n; i++) beat(sel, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_valid1", ev1, 0);
      check("idle_valid8", ev8, 0);
      check("idle_lock1", locked1, m_lk[0]);
      check("idle_lock8", locked8, m_lk[1]);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ready1", ready1, 0);
    check("rst_locked1", locked1, 0);
    check("rst_valid1", ev1, 0);
    check("rst_bits1", eb1, 0);
    check("rst_count1", ec1, 0);
    check("rst_ready8", ready8, 0);
    check("rst_locked8", locked8, 0);
    check("rst_valid8", ev8, 0);
    check("rst_bits8", eb8, 0);
    check("rst_count8", ec8, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    restart1 = 1'b0; clear1 = 1'b0; valid1 = 1'b0; data1 = '0;
    restart8 = 1'b0; clear8 = 1'b0; valid8 = 1'b0; data8 = '0;
    model_reset(0); model_reset(1);
    m_cnt[0] = 0; m_cnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready1_up", ready1, 1);
    check("ready8_up", ready8, 1);

    // Lock on a clean stream: locked must rise with the 16th beat.
    beat(0, 8'h01, 1'b1, 1'b0, 1'b0);
    check("seed_bit0", eb1, 0);
    clean(0, 14);
    check("no_early_lock", locked1, 0);
    clean(0, 1);
    check("lock_at_16", locked1, 1);

    // Single-bit error while locked, then loss of lock and relock.
    beat(0, 8'h01, 1'b0, 1'b0, 1'b0);
    check("single_err_lock", locked1, 1);
    clean(0, 4);
    for (int i = 0; i < 4; i++) beat(0, 8'h01, 1'b0, 1'b0, 1'b0);
    check("loss_of_lock", locked1, 0);
    clean(0, 16);
    check("relock", locked1, 1);
    idle(3);

    // Restart with a coincident beat, then a hunt interrupted by one errored beat.
    saved_cnt = m_cnt[0];
    beat(0, 8'h01, 1'b0, 1'b1, 1'b0);
    clean(0, 10);
    beat(0, 8'h01, 1'b0, 1'b0, 1'b0);
    clean(0, 15);
    check("hunt_reset_no_lock", locked1, 0);
    clean(0, 1);
    check("hunt_relock", locked1, 1);
`ifdef LFSR_CHK_ERRCNT_EN
    check("hunt_count_kept", ec1, saved_cnt);
`else
    check("hunt_count_kept", ec1, 0);
`endif
    beat(0, 8'h01, 1'b0, 1'b0, 1'b1);
    check("clear_wins", ec1, 0);

    // 8-bit beats: first byte from seed 7F is 0x3F LSB-first.
    beat(1, 8'h3F, 1'b1, 1'b0, 1'b0);
    check("seed_byte", eb8, 0);
    clean(1, 15);
    check("lock8", locked8, 1);
    beat(1, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat(1, 8'hFF, 1'b0, 1'b0, 1'b0);
    clean(1, 1);
    beat(1, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      beat(1, 8'h01 << $urandom_range(7, 0), 1'b0, 1'b0, 1'b0);
      clean(1, 1);
    end
`ifdef LFSR_CHK_ERRCNT_EN
    check("sat15", ec8, 15);
`else
    check("sat15", ec8, 0);
`endif
    check("lock8_held", locked8, 1);
    idle(2);

    // Asynchronous reset mid-stream.
    valid1 = 1'b1; valid8 = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    valid1 = 1'b0; valid8 = 1'b0;
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_galois_checker.md
# lfsr_galois_checker

Receive-side PRBS checker for Galois-LFSR data streams. It regenerates the expected sequence from the same polynomial and seed as the transmit-side generator, and compares it against each incoming beat. Alignment is tracked with a HUNT/LOCKED state machine, and bit errors are counted while locked. It sits at the sink end of link/loopback test paths, opposite the PRBS generator.

## Interface
- POLY_DEGREE, 7, LFSR length; state is indexed [POLY_DEGREE:1].
- POLYNOMIAL, 7'b110_0000, Galois tap mask XORed into the state after the shift.
- SEED, all-ones, expected LFSR state at sequence start; must be non-zero.
- OUTPUT_WIDTH, 1, bits per beat.
- LOCK_BEATS, 16, consecutive clean beats needed to enter LOCKED.
- LOSS_BEATS, 4, consecutive errored beats needed to drop to HUNT.
- CNT_W, 32, width of the error counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- restart  in  1  single-cycle pulse that re-aligns the checker to SEED.
- clear_count  in  1  synchronous clear of err_count.
- s_valid  in  1  input beat valid.
- s_ready  out  1  beat accept.
- s_data  in  OUTPUT_WIDTH  received beat; bit 0 is the first bit in sequence order.
- locked  out  1  high while in LOCKED.
- err_valid  out  1  one-cycle strobe per accepted beat.
- err_bits  out  OUTPUT_WIDTH  s_data XOR expected for that beat.
- err_count  out  CNT_W  saturating count of errored bits seen while LOCKED.

## Operation
- **LFSR step, one per bit:**
  - out = state[1].
  - state = state >> 1.
  - If out = 1, state ^= POLYNOMIAL.
- **Expected beat:** OUTPUT_WIDTH successive steps. Bit i is the i-th output bit. The state register advances by OUTPUT_WIDTH steps per accepted beat.
- **Beat acceptance:** a beat is accepted when s_valid && s_ready. s_ready is low in reset and high from the first clock after rst_n deasserts. There is no backpressure otherwise.
- **Beat classification:** a beat is errored when err_bits != 0 and clean otherwise.
- **FSM:**
  - HUNT (reset state):
    - Clean beat: good_run++.
    - Errored beat: good_run = 0.
    - When good_run reaches LOCK_BEATS, go to LOCKED and set bad_run = 0.
  - LOCKED:
    - Errored beat: bad_run++ and err_count += popcount(err_bits), saturating at 2^CNT_W-1.
    - Clean beat: bad_run = 0.
    - When bad_run reaches LOSS_BEATS, go to HUNT and set good_run = 0.
  - In both states the LFSR always advances on an accepted beat.
- **restart:** sets state = SEED, FSM = HUNT, good_run = 0 and bad_run = 0. err_count is kept.
  - A beat accepted in the same cycle as restart is discarded: no err_valid and no LFSR advance.
  - The next accepted beat is compared against the SEED sequence.
- **clear_count:** err_count = 0. If it coincides with an errored LOCKED beat, the clear wins and that beat's errors are dropped.
- **Reset values:** state = SEED, FSM = HUNT, locked = 0, err_valid = 0, err_bits = 0, err_count = 0, s_ready = 0.

## Timing
- All outputs are registered.
- err_valid and err_bits appear 1 cycle after the accepting edge.
- locked and err_count update on the same edge that registers err_bits.
- The LOCK_BEATS-th clean beat raises locked 1 cycle after its acceptance.
- The LOSS_BEATS-th errored beat drops locked 1 cycle after its acceptance.
  - That beat's errors are still counted.
- Back-to-back beats are supported at one per cycle. Idle cycles (s_valid = 0) hold all counters, hold the FSM, and keep err_valid = 0.
- Asserting rst_n low mid-stream immediately returns every output to its reset value, asynchronously.

## Configuration
- **LFSR_CHK_ERRCNT_EN defined:**
  - err_count accumulates as specified.
  - clear_count is active.
- **LFSR_CHK_ERRCNT_EN undefined:**
  - The error counter is not built.
  - err_count is tied to 0 and clear_count is ignored.
  - FSM, locked, err_valid and err_bits are unchanged.

## Test plan
- **Lock on a clean stream:** defaults (SEED = 7'h7F, width 1). Drive a clean generator stream from the same seed.
  - locked rises 1 cycle after beat 16 is accepted.
  - err_bits stays 0 and err_count = 0.
- **Single-bit error while LOCKED:** after lock, flip one bit on one beat.
  - err_bits = 1 on that beat.
  - err_count = 1 and locked stays high.
- **Loss of lock:** after lock, drive 4 consecutive inverted beats.
  - err_count = 4 and locked falls after the 4th beat.
  - Then 16 clean beats relock, because the LFSR kept advancing.
- **Hunt reset:** a clean run of 10 beats, 1 errored beat, then clean beats.
  - locked rises only after 16 further clean beats.
  - err_count is unchanged, since counting is disabled in HUNT.
- **Restart and clear_count coincident:**
  - restart with a beat in the same cycle: the beat is dropped with no err_valid, the next beat matches SEED output, and the FSM is in HUNT.
  - clear_count together with an errored LOCKED beat: err_count = 0.
- **Width and saturation:** OUTPUT_WIDTH = 8, CNT_W = 4.
  - Beats match an 8-step bit-serial model, LSB first.
  - Repeated 0xFF error beats while LOCKED saturate err_count at 15.
  - Rerun with LFSR_CHK_ERRCNT_EN undefined: err_count stays 0.
